// File: rtl/bus_pkg.sv
// Shared bus definitions: data/byte-enable/burst widths and the target FSM states.
package bus_pkg;

  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int BURST_W = 8;
  // Beat counter holds burst_size+1, so one bit wider than the burst field.
  localparam int CNT_W   = BURST_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RDWAIT,
    READ,
    RDEND,
    WRITE,
    ERR
  } state_e;

endpackage

// File: rtl/bus_sram_mem.sv
// Single-port SRAM, 2^ADDR_BITS x 32, synchronous read and byte-enable write.
module bus_sram_mem
  import bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [BE_W-1:0]      be,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_q[addr];
  end

  // NOTE: the array and read register are deliberately not reset; contents
  // must survive a bus reset and a reset would prevent RAM inference.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_sram_target.sv
// Bus SRAM target: claims transactions in its address window and serves
// read/write bursts from a local single-port SRAM.
module bus_sram_target
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS     = 32'h5000_0000,
  parameter int          ADDR_BITS        = 10,
  parameter int          READ_WAIT        = 0,
  parameter int          WRITE_BUSY_EVERY = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               begin_transaction_in,
  input  logic               end_transaction_in,
  input  logic               read_n_write_in,
  input  logic               data_valid_in,
  input  logic               busy_in,
  input  logic [DATA_W-1:0]  address_data_in,
  input  logic [BE_W-1:0]    byte_enables_in,
  input  logic [BURST_W-1:0] burst_size_in,
  output logic [DATA_W-1:0]  address_data_out,
  output logic               end_transaction_out,
  output logic               data_valid_out,
  output logic               busy_out,
  output logic               error_out
);

  localparam int TICK_W = 16;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic                 busy_q, busy_d;
  logic                 hit;
  logic                 accept_wr;
  logic                 mem_rd_en, mem_wr_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_rdata;

  assign hit = address_data_in[DATA_W-1:ADDR_BITS+2] == BASE_ADDRESS[DATA_W-1:ADDR_BITS+2];

  assign accept_wr = (state_q == WRITE) && data_valid_in && !busy_q && (cnt_q != '0);

  // tick_q counts read wait cycles in RDWAIT and accepted beats in WRITE.
  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_transaction_in && hit) begin
          addr_d = address_data_in[ADDR_BITS+1:2];
          cnt_d  = CNT_W'(burst_size_in) + CNT_W'(1);
          tick_d = '0;
          if (address_data_in[1:0] != 2'b00) state_d = ERR;
          else if (read_n_write_in)          state_d = RDWAIT;
          else                               state_d = WRITE;
        end
      end
      RDWAIT: begin
        if (end_transaction_in)                state_d = IDLE;
        else if (tick_q == TICK_W'(READ_WAIT)) state_d = READ;
        else                                   tick_d  = tick_q + TICK_W'(1);
      end
      READ: begin
        if (end_transaction_in) begin
          state_d = IDLE;
        end else if (!busy_in) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = RDEND;
          end else begin
            cnt_d  = cnt_q - CNT_W'(1);
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
      end
      WRITE: begin
        if (accept_wr) begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = addr_q + ADDR_BITS'(1);
          // No stall after the final beat: nothing is left to hold off.
          if (WRITE_BUSY_EVERY > 0 && cnt_q != CNT_W'(1)) begin
            if (tick_q == TICK_W'(WRITE_BUSY_EVERY - 1)) begin
              tick_d = '0;
              busy_d = 1'b1;
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
        end
        if (end_transaction_in) state_d = IDLE;
      end
      RDEND:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads are issued on the next address so the registered SRAM output
  // always holds the word at addr_q; writes go to the current word.
  assign mem_wr_en = accept_wr && !reset;
  assign mem_rd_en = ((state_d == RDWAIT) || (state_d == READ)) && !reset;
  assign mem_addr  = (state_q == WRITE) ? addr_q : addr_d;

  bus_sram_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clock (clock),
    .rd_en (mem_rd_en),
    .wr_en (mem_wr_en),
    .addr  (mem_addr),
    .wdata (address_data_in),
    .be    (byte_enables_in),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are zero unless the state actively drives them (wired-OR bus).
  assign data_valid_out      = (state_q == READ);
  assign address_data_out    = (state_q == READ) ? mem_rdata : '0;
  assign end_transaction_out = (state_q == RDEND) || (state_q == ERR);
  assign error_out           = (state_q == ERR);
  assign busy_out            = (state_q == WRITE) && busy_q;

endmodule

// File: tb/tb_bus_sram_target.sv
// Directed self-checking bench for bus_sram_target (busy inserted every 2 write beats).
module tb_bus_sram_target;

  logic        clock;
  logic        reset;
  logic        begin_transaction_in, end_transaction_in, read_n_write_in;
  logic        data_valid_in, busy_in;
  logic [31:0] address_data_in;
  logic [3:0]  byte_enables_in;
  logic [7:0]  burst_size_in;
  logic [31:0] address_data_out;
  logic        end_transaction_out, data_valid_out, busy_out, error_out;
  logic [35:0] outs;

  int n_checks;
  int n_fail;
  logic [31:0] exp_data [8];

  bus_sram_target #(
    .WRITE_BUSY_EVERY(2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in  (end_transaction_in),
    .read_n_write_in     (read_n_write_in),
    .data_valid_in       (data_valid_in),
    .busy_in             (busy_in),
    .address_data_in     (address_data_in),
    .byte_enables_in     (byte_enables_in),
    .burst_size_in       (burst_size_in),
    .address_data_out    (address_data_out),
    .end_transaction_out (end_transaction_out),
    .data_valid_out      (data_valid_out),
    .busy_out            (busy_out),
    .error_out           (error_out)
  );

  assign outs = {address_data_out, end_transaction_out, data_valid_out, busy_out, error_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] bsize,
                             input logic [3:0] be, output int busy_seen);
    int tries;
    busy_seen            = 0;
    begin_transaction_in = 1'b1;
    address_data_in      = addr;
    read_n_write_in      = 1'b0;
    burst_size_in        = bsize;
    tick();
    begin_transaction_in = 1'b0;
    for (int b = 0; b <= int'(bsize); b++) begin
      data_valid_in   = 1'b1;
      address_data_in = exp_data[b & 7];
      byte_enables_in = be;
      tries = 0;
      while (busy_out && tries < 8) begin
        busy_seen++;
        tries++;
        tick();
      end
      tick();
    end
    data_valid_in   = 1'b0;
    address_data_in = '0;
    if (busy_out) busy_seen++;
    end_transaction_in = 1'b1;
    tick();
    end_transaction_in = 1'b0;
  endtask

  // Cycle numbers are counted from the claiming edge (claim edge = 0).
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] bsize,
                            input int stall_beat, input int stall_len,
                            output int first_dv, output int end_at, output int beats);
    int  stall_left;
    bit  done;
    first_dv   = -1;
    end_at     = -1;
    beats      = 0;
    stall_left = stall_len;
    done       = 1'b0;
    begin_transaction_in = 1'b1;
    address_data_in      = addr;
    read_n_write_in      = 1'b1;
    burst_size_in        = bsize;
    tick();
    begin_transaction_in = 1'b0;
    address_data_in      = '0;
    read_n_write_in      = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      busy_in = (beats == stall_beat) && (stall_left > 0) && data_valid_out;
      if (data_valid_out) begin
        if (first_dv < 0) first_dv = k;
        check($sformatf("rd_beat%0d", beats), address_data_out, exp_data[beats & 7]);
        if (busy_in) stall_left--;
        else         beats++;
      end
      if (end_transaction_out) begin
        end_at = k;
        done   = 1'b1;
      end else begin
        tick();
      end
    end
    busy_in = 1'b0;
    if (!done) check("rd_timeout", 0, 1);
    else       tick();
  endtask

  initial begin
    int busy_seen, first_dv, end_at, beats;
    logic [35:0] acc;
    n_checks = 0;
    n_fail   = 0;
    reset                = 1'b1;
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b0;
    read_n_write_in      = 1'b0;
    data_valid_in        = 1'b0;
    busy_in              = 1'b0;
    address_data_in      = '0;
    byte_enables_in      = 4'hF;
    burst_size_in        = '0;
    repeat (3) tick();
    check("reset_outs", outs, 0);
    reset = 1'b0;
    tick();

    // Single beat write then read back.
    exp_data[0] = 32'hDEAD_BEEF;
    write_burst(32'h5000_0010, 8'd0, 4'hF, busy_seen);
    check("single_wr_busy", busy_seen, 0);
    read_burst(32'h5000_0010, 8'd0, -1, 0, first_dv, end_at, beats);
    check("single_first_dv", first_dv, 2);
    check("single_end_at", end_at, 3);
    check("single_beats", beats, 1);

    // Four-beat burst wrapping from word 1022 to word 1.
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA000_0000 + 32'(i);
    write_burst(32'h5000_0FF8, 8'd3, 4'hF, busy_seen);
    check("burst_wr_busy", busy_seen, 1);
    read_burst(32'h5000_0FF8, 8'd3, -1, 0, first_dv, end_at, beats);
    check("burst_beats", beats, 4);
    check("burst_first_dv", first_dv, 2);
    check("burst_end_at", end_at, 6);
    exp_data[0] = 32'hA000_0002;
    read_burst(32'h5000_0000, 8'd0, -1, 0, first_dv, end_at, beats);
    check("wrap_word0_beats", beats, 1);

    // Byte enables.
    exp_data[0] = 32'h1122_3344;
    write_burst(32'h5000_0020, 8'd0, 4'hF, busy_seen);
    exp_data[0] = 32'hAABB_CCDD;
    write_burst(32'h5000_0020, 8'd0, 4'b0101, busy_seen);
    exp_data[0] = 32'h11BB_33DD;
    read_burst(32'h5000_0020, 8'd0, -1, 0, first_dv, end_at, beats);
    check("be_beats", beats, 1);

    // Read stall: busy_in high for 2 cycles on the second beat.
    for (int i = 0; i < 3; i++) exp_data[i] = 32'hC000_0000 + 32'(i);
    write_burst(32'h5000_0040, 8'd2, 4'hF, busy_seen);
    check("stall_wr_busy", busy_seen, 1);
    read_burst(32'h5000_0040, 8'd2, 1, 2, first_dv, end_at, beats);
    check("stall_beats", beats, 3);
    check("stall_end_at", end_at, 7);

    // Eight-beat write with target busy every 2 beats.
    for (int i = 0; i < 8; i++) exp_data[i] = 32'hD000_0000 + 32'(i);
    write_burst(32'h5000_0100, 8'd7, 4'hF, busy_seen);
    check("wr8_busy_cycles", busy_seen, 3);
    read_burst(32'h5000_0100, 8'd7, -1, 0, first_dv, end_at, beats);
    check("wr8_beats", beats, 8);
    check("wr8_end_at", end_at, 10);

    // Misaligned address: error and end together at T+1.
    begin_transaction_in = 1'b1;
    address_data_in      = 32'h5000_0002;
    read_n_write_in      = 1'b1;
    burst_size_in        = 8'd0;
    tick();
    begin_transaction_in = 1'b0;
    address_data_in      = '0;
    check("err_t1", {error_out, end_transaction_out, data_valid_out}, 3'b110);
    tick();
    check("err_t2_idle", outs, 0);

    // Address outside the window: never claimed.
    begin_transaction_in = 1'b1;
    address_data_in      = 32'h6000_0000;
    read_n_write_in      = 1'b1;
    acc = '0;
    tick();
    begin_transaction_in = 1'b0;
    address_data_in      = '0;
    for (int i = 0; i < 5; i++) begin
      acc |= outs;
      tick();
    end
    check("miss_outs", acc, 0);

    // Abort during READ: back to idle with no end pulse.
    begin_transaction_in = 1'b1;
    address_data_in      = 32'h5000_0FF8;
    read_n_write_in      = 1'b1;
    burst_size_in        = 8'd3;
    tick();
    begin_transaction_in = 1'b0;
    address_data_in      = '0;
    tick();
    check("abort_pre_dv", data_valid_out, 1);
    end_transaction_in = 1'b1;
    tick();
    end_transaction_in = 1'b0;
    check("abort_outs", outs, 0);
    tick();
    check("abort_idle", outs, 0);

    // Reset during the second read beat; memory must survive.
    begin_transaction_in = 1'b1;
    address_data_in      = 32'h5000_0FF8;
    read_n_write_in      = 1'b1;
    burst_size_in        = 8'd3;
    tick();
    begin_transaction_in = 1'b0;
    address_data_in      = '0;
    tick();
    tick();
    check("rst_beat2_data", address_data_out, 32'hA000_0001);
    reset = 1'b1;
    tick();
    check("rst_outs", outs, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA000_0000 + 32'(i);
    read_burst(32'h5000_0FF8, 8'd3, -1, 0, first_dv, end_at, beats);
    check("rst_mem_beats", beats, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_sram_target.md
BUS_SRAM_TARGET -- requirements
Module: bus_sram_target

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5000_0000, byte address of word 0.
REQ-002 SHALL have parameter ADDR_BITS, default 10, giving memory depth 2^ADDR_BITS 32-bit words.
REQ-003 SHALL have parameter READ_WAIT, default 0, giving extra cycles before the first read beat.
REQ-004 SHALL have parameter WRITE_BUSY_EVERY, default 0, giving the busy insertion period (0 = never busy).
REQ-005 SHALL have port clock  in  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have inputs, all 1 bit: begin_transaction_in, end_transaction_in, read_n_write_in, data_valid_in, busy_in (initiator stall).
REQ-008 SHALL have inputs address_data_in [31:0], byte_enables_in [3:0], burst_size_in [7:0] (beats minus 1).
REQ-009 SHALL have outputs address_data_out [31:0], end_transaction_out, data_valid_out, busy_out and error_out (1 bit each).

Function
REQ-010 SHALL claim a transaction when begin_transaction_in=1, state IDLE, and address_data_in[31:ADDR_BITS+2]==BASE_ADDRESS[31:ADDR_BITS+2]; otherwise it stays IDLE.
REQ-011 SHALL latch the word address address_data_in[ADDR_BITS+1:2], read_n_write_in, burst_size_in and byte_enables_in on the claiming edge.
REQ-012 SHALL, for a claimed transaction with address_data_in[1:0]!=0, pulse error_out and end_transaction_out together for 1 cycle at T+1, access no memory, and return to IDLE.
REQ-013 SHALL use states IDLE, RDWAIT, READ, RDEND, WRITE and ERR.
REQ-014 SHALL use these transitions: claim to RDWAIT / WRITE / ERR; RDWAIT to READ after READ_WAIT+1 cycles; READ to RDEND after the last beat is accepted; RDEND, ERR and WRITE-end to IDLE.
REQ-015 SHALL, on a read claimed at edge T, present the first beat with data_valid_out=1 at cycle T+2+READ_WAIT.
REQ-016 SHALL accept a read beat in any cycle where data_valid_out=1 and busy_in=0; while busy_in=1, data and address are held and do not advance.
REQ-017 SHALL deliver exactly burst_size+1 read beats, then pulse end_transaction_out for 1 cycle, with data_valid_out=0 in that cycle.
REQ-018 SHALL, on a write, write address_data_in to the current word with byte_enables_in masking in each cycle where data_valid_in=1 and busy_out=0, then increment the address.
REQ-019 SHALL, when WRITE_BUSY_EVERY=N>0, assert busy_out for 1 cycle after every N accepted beats; a beat offered during busy is not written.
REQ-020 SHALL ignore write beats beyond burst_size+1 and return to IDLE on end_transaction_in.
REQ-021 SHALL wrap the word address modulo 2^ADDR_BITS within a burst.
REQ-022 SHALL, on end_transaction_in during RDWAIT or READ, abort to IDLE next cycle with no end_transaction_out.
REQ-023 SHALL ignore begin_transaction_in in any state other than IDLE.
REQ-024 SHALL drive every output to 0 whenever not actively driving (OR-bus).

Reset
REQ-025 SHALL, on reset, set state IDLE and all outputs to 0 at the next cycle, including when reset occurs mid-transaction.
REQ-026 SHALL leave memory contents unchanged by reset.

Structure
REQ-027 SHALL take the state enum, the bus width constants (32/4/8) and the burst counter width from a shared package bus_pkg.
REQ-028 SHALL instantiate one sub-module, bus_sram_mem: single port, synchronous read, byte-enable write, 2^ADDR_BITS x 32.

Verification
REQ-029 SHALL cover single write: write 32'hDEADBEEF to 0x5000_0010 with be=4'hF, then read it back; expect first data_valid_out at T+2 and end_transaction_out at T+3.
REQ-030 SHALL cover burst: write 4 beats (burst_size=3) at 0x5000_0FF8, then read 4 beats; expect data at words 1022, 1023, 0, 1 (wrap).
REQ-031 SHALL cover byte enables: write 32'h11223344 then 32'hAABBCCDD with be=4'b0101; expect readback 32'h11BB33DD.
REQ-032 SHALL cover stalls: read burst of 3 with busy_in high 2 cycles mid-burst; expect held data and exactly 3 beats; with WRITE_BUSY_EVERY=2, an 8-beat write shows 3 busy cycles.
REQ-033 SHALL cover errors and misses: address 0x5000_0002 gives error_out + end_transaction_out at T+1; address 0x6000_0000 gives all outputs 0.
REQ-034 SHALL cover reset mid-burst: reset asserted during read beat 2; outputs 0 next cycle and prior memory contents intact.
